// File: rtl/i_tree_pkg.sv
// rtl/i_tree_pkg.sv - shared i_tree serial-link defaults
// Purpose: single source for the serial word width and fill word used by both
//          the InputBuffer deframer and the sensor_serializer source.
// Ports:   none (package).
package i_tree_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_IDLE_WORD = 8'h00;
  localparam int DEFAULT_CNT_WIDTH = 16;

  // Width of a bit-phase counter able to index 0..width-1.
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sensor_serializer.sv
// rtl/sensor_serializer.sv - parallel sample to MSB-first serial stream source
// Purpose: accepts samples over valid/ready into a one-entry hold buffer and
//          shifts each word out MSB-first, one bit per clock, on a continuous,
//          reset-aligned stream; a fill word is sent when no sample is ready.
// Ports:
//   clk            in   single rising-edge clock
//   reset          in   synchronous, active-high
//   sample_data    in   DATA_WIDTH parallel sample
//   sample_valid   in   sample_data is valid
//   sample_ready   out  hold buffer empty; transfer on valid && ready
//   sensor_data    out  serial bit (MSB of the shift register)
//   word_start     out  high while the MSB of a word is on sensor_data
//   underrun       out  one-cycle pulse when the fill word was loaded
//   underrun_count out  saturating count of underruns
module sensor_serializer
  import i_tree_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD = DATA_WIDTH'(DEFAULT_IDLE_WORD),
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  sensor_data,
  output logic                  word_start,
  output logic                  underrun,
  output logic [CNT_WIDTH-1:0]  underrun_count
);

  localparam int IDX_W = idx_width(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [IDX_W-1:0]      bit_idx;
  logic                  hold_full;
  logic                  underrun_q;
  logic [CNT_WIDTH-1:0]  cnt;

  logic load_edge;
  logic accept;

  assign load_edge = (bit_idx == LAST_IDX);
  // Ready comes straight from the hold flop, so it never depends on valid.
  assign accept    = sample_valid && !hold_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= IDLE_WORD;
      hold_data  <= '0;
      bit_idx    <= '0;
      hold_full  <= 1'b0;
      underrun_q <= 1'b0;
      cnt        <= '0;
    end else begin
      underrun_q <= 1'b0;

      if (load_edge) begin
        bit_idx <= '0;
        if (hold_full) begin
          shreg <= hold_data;
        end else begin
          // A sample arriving on this same edge lands in hold, not here:
          // there is deliberately no bypass into the shift register.
          shreg      <= IDLE_WORD;
          underrun_q <= 1'b1;
          if (cnt != '1) begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
      end else begin
        shreg   <= shreg << 1;
        bit_idx <= bit_idx + IDX_W'(1);
      end

      // Load-with-hold-full and accept are exclusive since ready is low then.
      if (load_edge && hold_full) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_data <= sample_data;
        hold_full <= 1'b1;
      end
    end
  end

  assign sensor_data    = shreg[DATA_WIDTH-1];
  assign word_start     = (bit_idx == '0);
  assign sample_ready   = !hold_full;
  assign underrun       = underrun_q;
  assign underrun_count = cnt;

endmodule

// File: tb/tb_sensor_serializer.sv
// tb/tb_sensor_serializer.sv - directed scoreboard bench for sensor_serializer
module tb_sensor_serializer;

  localparam logic [7:0] IDLE = 8'h00;

  logic        clk;
  logic        reset;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        sensor_data;
  logic        word_start;
  logic        underrun;
  logic [15:0] underrun_count;

  int checks;
  int errors;

  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  sensor_serializer dut (
    .clk            (clk),
    .reset          (reset),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .sensor_data    (sensor_data),
    .word_start     (word_start),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Present tx_q in order with valid held high; pop on each accepted transfer.
  task automatic send_all(input int bound);
    int   n;
    logic rdy;
    n = 0;
    while (tx_q.size() > 0 && n < bound) begin
      sample_data  = tx_q[0];
      sample_valid = 1'b1;
      rdy = sample_ready;
      next_cycle();
      if (rdy) void'(tx_q.pop_front());
      n++;
    end
    sample_valid = 1'b0;
    chk("send_timeout", 32'(tx_q.size()), 32'd0);
  endtask

  // Wait for the scoreboard to drain, checking the underrun count each cycle.
  task automatic wait_drain(input int bound, input logic [15:0] exp_cnt);
    int n;
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      #1;
      chk("drain_cnt", 32'(underrun_count), 32'(exp_cnt));
      if (exp_q.size() == 0) break;
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    next_cycle();
  endtask

  // Deframer: collect words aligned to word_start and score them in order.
  initial begin
    logic [7:0] w;
    logic [7:0] e;
    int         n;
    n = 0;
    w = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        n = 0;
      end else begin
        if (word_start) begin
          w = {7'b0, sensor_data};
          n = 1;
        end else if (n > 0) begin
          w = {w[6:0], sensor_data};
          n++;
        end
        if (n == 8) begin
          n = 0;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rx_word", 32'(w), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] r;
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_data  = '0;

    // Idle stream: fill words, word_start every 8, underruns at boundaries.
    do_reset();
    repeat (3) exp_q.push_back(IDLE);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("rst_ready", 32'(sample_ready), 32'd1);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_cnt", 32'(underrun_count), 32'd0);
      end
      chk($sformatf("idle_sd_c%0d", k), 32'(sensor_data), 32'd0);
      chk($sformatf("idle_ws_c%0d", k), 32'(word_start), 32'(k % 8 == 0));
      chk($sformatf("idle_ur_c%0d", k), 32'(underrun), 32'(k == 8 || k == 16));
      if (k == 23) chk("idle_cnt", 32'(underrun_count), 32'd2);
      next_cycle();
    end
    chk("idle_drain", 32'(exp_q.size()), 32'd0);

    // Single sample A5 accepted in cycle 0, emitted on cycles 8..15.
    do_reset();
    exp_q.push_back(IDLE);
    exp_q.push_back(8'hA5);
    pat = 8'hA5;
    chk("a5_ready_c0", 32'(sample_ready), 32'd1);
    sample_data  = 8'hA5;
    sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      if (k <= 7) chk($sformatf("a5_ready_c%0d", k), 32'(sample_ready), 32'd0);
      if (k >= 8) begin
        chk($sformatf("a5_sd_c%0d", k), 32'(sensor_data), 32'(pat[15-k]));
        chk($sformatf("a5_ws_c%0d", k), 32'(word_start), 32'(k == 8));
      end
      if (k == 8) chk("a5_no_underrun", 32'(underrun), 32'd0);
      next_cycle();
    end
    chk("a5_drain", 32'(exp_q.size()), 32'd0);

    // Back-to-back samples with valid held high: no underruns.
    do_reset();
    exp_q.push_back(IDLE);
    tx_q = '{8'h81, 8'h3C, 8'hFF};
    foreach (tx_q[i]) exp_q.push_back(tx_q[i]);
    send_all(100);
    wait_drain(200, 16'd0);

    // C3 presented exactly on the load edge with hold empty.
    do_reset();
    exp_q.push_back(IDLE);
    exp_q.push_back(IDLE);
    exp_q.push_back(8'hC3);
    repeat (7) next_cycle();
    chk("c3_ready_c7", 32'(sample_ready), 32'd1);
    sample_data  = 8'hC3;
    sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    @(negedge clk);
    chk("c3_underrun", 32'(underrun), 32'd1);
    chk("c3_cnt", 32'(underrun_count), 32'd1);
    chk("c3_ready_c8", 32'(sample_ready), 32'd0);
    chk("c3_ws_c8", 32'(word_start), 32'd1);
    chk("c3_sd_c8", 32'(sensor_data), 32'd0);
    wait_drain(100, 16'd1);

    // Reset mid-word (F0 at bit_idx 4) with 0F held: 0F must never appear.
    do_reset();
    exp_q.push_back(IDLE);
    exp_q.push_back(IDLE);
    repeat (8) next_cycle();
    sample_data  = 8'hF0;
    sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    repeat (7) next_cycle();
    sample_data  = 8'h0F;
    sample_valid = 1'b1;
    next_cycle();
    sample_valid = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("mid_cnt_before", 32'(underrun_count), 32'd1);
    chk("mid_ready_before", 32'(sample_ready), 32'd0);
    chk("mid_ws_before", 32'(word_start), 32'd0);
    chk("mid_pre_drain", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    repeat (3) exp_q.push_back(IDLE);
    @(negedge clk);
    chk("mid_ws", 32'(word_start), 32'd1);
    chk("mid_sd", 32'(sensor_data), 32'd0);
    chk("mid_ready", 32'(sample_ready), 32'd1);
    chk("mid_cnt", 32'(underrun_count), 32'd0);
    repeat (24) next_cycle();
    chk("mid_drain", 32'(exp_q.size()), 32'd0);

    // Loopback: 16 random samples deframed in order.
    do_reset();
    exp_q.push_back(IDLE);
    tx_q.delete();
    for (int i = 0; i < 16; i++) begin
      r = 8'($urandom_range(0, 255));
      tx_q.push_back(r);
      exp_q.push_back(r);
    end
    send_all(400);
    wait_drain(300, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
